// File: rtl/alu_param_core_if.sv
// alu_param_core_if: start/done request bus between the operand register
// file (master) and alu_param_core (slave). WIDTH must match the core.
// The flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_param_core_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [2:0]             opcode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     result;
    logic                   done;
    logic                   busy;
`ifdef ALU_FLAGS_EN
    logic                   flag_zero;
    logic                   flag_carry;
    logic                   flag_neg;
`endif

`ifdef ALU_FLAGS_EN
    modport master (output start, opcode, A, B,
                    input  result, done, busy, flag_zero, flag_carry, flag_neg);
    modport slave  (input  start, opcode, A, B,
                    output result, done, busy, flag_zero, flag_carry, flag_neg);
`else
    modport master (output start, opcode, A, B,
                    input  result, done, busy);
    modport slave  (input  start, opcode, A, B,
                    output result, done, busy);
`endif
endinterface

// File: rtl/alu_param_core.sv
// alu_param_core: parametrised start/done ALU with a multi-cycle MUL.
// Operands are captured when start is accepted; the result and a one-cycle
// done pulse appear one clock later (MUL_LAT clocks later for MUL).
// A start held high after done never launches a second op (REARM).
// Optional build macro ALU_FLAGS_EN adds zero/carry/neg flags.
module alu_param_core #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_param_core_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_INC = 3'd7;

    // DONE is the cycle in which the result is committed; done/result
    // become visible on the edge that leaves DONE.
    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE, REARM} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [RW-1:0]     a_ext, b_ext, alu_res;
    logic [RW-1:0]     result_q;
    logic              done_q, busy_q;
    logic              accept;
    logic              mul_last;

    assign accept   = (state == IDLE) && bus.start;
    assign mul_last = (cnt == CW'(MUL_LAT - 2));
    assign a_ext    = {{WIDTH{1'b0}}, a_q};
    assign b_ext    = {{WIDTH{1'b0}}, b_q};

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.opcode == OP_MUL) ? MUL_RUN : DONE;
            MUL_RUN: if (mul_last)  state_nxt = DONE;
            DONE:    state_nxt = bus.start ? REARM : IDLE;
            REARM:   if (!bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // MUL cycle counter: cleared on acceptance, counts through MUL_RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               cnt <= '0;
        else if (accept)            cnt <= '0;
        else if (state == MUL_RUN)  cnt <= cnt + 1'b1;
    end

    // Operand/opcode capture; later bus changes are ignored until next accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= OP_NOP;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.opcode;
            a_q  <= bus.A;
            b_q  <= bus.B;
        end
    end

    // Result datapath on the captured operands, modulo 2^RW
    always_comb begin
        alu_res = result_q;
        case (op_q)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_NOT:  alu_res = ~a_ext;
            OP_XOR:  alu_res = a_ext ^ b_ext;
            OP_AND:  alu_res = a_ext & b_ext;
            OP_MUL:  alu_res = a_ext * b_ext;
            OP_INC:  alu_res = a_ext + b_ext + RW'(1);
            default: alu_res = result_q;
        endcase
    end

    // Output registers: result commits and done pulses when leaving DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if ((state == DONE) && (op_q != OP_NOP))
                result_q <= alu_res;
        end
    end

    // busy covers MUL from acceptance until the done edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          busy_q <= 1'b0;
        else if (accept && bus.opcode == OP_MUL) busy_q <= 1'b1;
        else if (state == DONE)                busy_q <= 1'b0;
    end

`ifdef ALU_FLAGS_EN
    logic carry_c;
    logic fz_q, fc_q, fn_q;

    assign bus.flag_zero  = fz_q;
    assign bus.flag_carry = fc_q;
    assign bus.flag_neg   = fn_q;

    // Carry out of the low WIDTH bits for add forms, borrow for SUB
    always_comb begin
        carry_c = 1'b0;
        case (op_q)
            OP_ADD, OP_INC: carry_c = alu_res[WIDTH];
            OP_SUB:         carry_c = (a_q < b_q);
            default:        carry_c = 1'b0;
        endcase
    end

    // Flags update alongside result; NOP leaves them untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fz_q <= 1'b0;
            fc_q <= 1'b0;
            fn_q <= 1'b0;
        end else if ((state == DONE) && (op_q != OP_NOP)) begin
            fz_q <= (alu_res == '0);
            fc_q <= carry_c;
            fn_q <= alu_res[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_param_core.sv
// tb_alu_param_core: directed vector table, hand-written reset/abort/re-arm
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_param_core;
    localparam int W   = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] prev_res = 16'h0;
`ifdef ALU_FLAGS_EN
    logic pz = 1'b0, pc = 1'b0, pn = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_param_core_if #(.WIDTH(W)) bus ();

    alu_param_core #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic reduced modulo 2^16
    function automatic logic [15:0] ref_alu(input int op, input int a, input int b, input logic [15:0] prev);
        int r;
        case (op)
            1: r = a + b;
            2: r = (a - b + 65536) % 65536;
            3: r = 65280 + (255 - a);
            4: r = a ^ b;
            5: r = a & b;
            6: r = a * b;
            7: r = a + b + 1;
            default: r = int'(prev);
        endcase
        return 16'(r % 65536);
    endfunction

    // One full transaction; returns result, edges to done and busy cycles
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, output logic [15:0] res,
                          output int lat, output int busy_cyc, output logic busy_at_done);
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
        @(posedge clk);
        lat = 0; busy_cyc = 0; seen = 0; busy_at_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.done) begin seen = 1; busy_at_done = bus.busy; break; end
            if (bus.busy) busy_cyc++;
            if (scramble) begin
                bus.opcode = 3'($urandom); bus.A = 8'($urandom); bus.B = 8'($urandom);
            end
            @(posedge clk);
            lat++;
        end
        if (!seen) lat = -1;
        res = bus.result;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse_width", {31'b0, bus.done}, 32'h0);
    endtask

    // Compare one completed op with the model and advance model state
    task automatic check_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input bit scramble, input logic [15:0] exp_tab,
                            input bit use_tab);
        logic [15:0] res, exp;
        int lat, bc;
        logic bad;
        exp = use_tab ? exp_tab : ref_alu(int'(op), int'(a), int'(b), prev_res);
        run_op(op, a, b, scramble, res, lat, bc, bad);
        chk({tag, "_result"}, {16'b0, res}, {16'b0, exp});
        chk({tag, "_latency"}, 32'(lat), (op == 3'd6) ? 32'(LAT) : 32'd1);
        chk({tag, "_busy_cycles"}, 32'(bc), (op == 3'd6) ? 32'(LAT) : 32'd0);
        chk({tag, "_busy_at_done"}, {31'b0, bad}, 32'h0);
`ifdef ALU_FLAGS_EN
        if (op != 3'd0) begin
            pz = (exp == 16'h0);
            pn = exp[7];
            if (op == 3'd1)      pc = (int'(a) + int'(b)) > 255;
            else if (op == 3'd7) pc = (int'(a) + int'(b) + 1) > 255;
            else if (op == 3'd2) pc = (a < b);
            else                 pc = 1'b0;
        end
        chk({tag, "_flags"}, {29'b0, bus.flag_zero, bus.flag_carry, bus.flag_neg}, {29'b0, pz, pc, pn});
`endif
        prev_res = exp;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int dn;
        vecs[0] = '{3'd1, 8'hFF, 8'h01, 16'h0100};
        vecs[1] = '{3'd7, 8'hFF, 8'h01, 16'h0101};
        vecs[2] = '{3'd2, 8'h03, 8'h05, 16'hFFFE};
        vecs[3] = '{3'd3, 8'h0F, 8'h00, 16'hFFF0};
        vecs[4] = '{3'd6, 8'hFF, 8'hFF, 16'hFE01};
        vecs[5] = '{3'd4, 8'hAA, 8'hFF, 16'h0055};
        vecs[6] = '{3'd5, 8'hF0, 8'h3C, 16'h0030};
        vecs[7] = '{3'd0, 8'h12, 8'h34, 16'h0030};
        vecs[8] = '{3'd2, 8'h05, 8'h03, 16'h0002};
        vecs[9] = '{3'd6, 8'h00, 8'h77, 16'h0000};

        // Reset held with start high
        bus.start = 1'b1; bus.opcode = 3'd1; bus.A = 8'd1; bus.B = 8'd2;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_result", {16'b0, bus.result}, 32'h0);
        chk("reset_done",   {31'b0, bus.done},   32'h0);
        chk("reset_busy",   {31'b0, bus.busy},   32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);  // first edge: accept
        @(posedge clk); #1;
        chk("first_edge_done",   {31'b0, bus.done}, 32'h1);
        chk("first_edge_result", {16'b0, bus.result}, 32'h3);
        @(negedge clk); bus.start = 1'b0;
        @(posedge clk);
        prev_res = 16'h3;
`ifdef ALU_FLAGS_EN
        pz = 1'b0; pc = 1'b0; pn = 1'b0;
`endif

        // Directed table; MUL entries scramble bus inputs mid-run
        for (int i = 0; i < 10; i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].op == 3'd6, vecs[i].exp, 1'b1);

        // Re-arm: start stays high 4 cycles past done
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 3'd1; bus.A = 8'h10; bus.B = 8'h20;
        @(posedge clk); @(posedge clk); #1;
        chk("rearm_first_done", {31'b0, bus.done}, 32'h1);
        dn = 0;
        repeat (4) begin @(posedge clk); #1; if (bus.done) dn++; end
        chk("rearm_no_second_done", 32'(dn), 32'h0);
        chk("rearm_result", {16'b0, bus.result}, 32'h30);
        @(negedge clk); bus.start = 1'b0;
        @(posedge clk);
        prev_res = 16'h0030;
`ifdef ALU_FLAGS_EN
        pz = 1'b0; pc = 1'b0; pn = 1'b0;
`endif
        check_op("rearm_xor", 3'd4, 8'hAA, 8'hFF, 1'b0, 16'h0055, 1'b1);

        // Abort: reset one cycle into a MUL
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 3'd6; bus.A = 8'hFF; bus.B = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        repeat (LAT + 3) begin @(posedge clk); #1; if (bus.done) dn++; end
        chk("abort_no_done",  32'(dn), 32'h0);
        chk("abort_result",   {16'b0, bus.result}, 32'h0);
        chk("abort_busy",     {31'b0, bus.busy}, 32'h0);
        prev_res = 16'h0;
`ifdef ALU_FLAGS_EN
        pz = 1'b0; pc = 1'b0; pn = 1'b0;
        check_op("flag_add", 3'd1, 8'hFF, 8'h01, 1'b0, 16'h0100, 1'b1);
`endif

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            check_op($sformatf("rnd%0d", i), op, 8'($urandom), 8'($urandom),
                     1'b1, 16'h0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_param_core.md
Name: alu_param_core

Overview:
Parametrised successor to the 8-bit tiny ALU, with the same start/done handshake and the same 3-bit opcode set. Operand width is set by a parameter. MUL has its own programmable multi-cycle latency. Adds a busy output and a re-arm rule for start. Sits between the operand register file and the result bus; it is the DUT for the block-level bench.

Parameters:
WIDTH, 8, operand width in bits (min 2); result width is 2*WIDTH.
MUL_LAT, 3, clocks from start acceptance edge to done edge for MUL (min 2).

Ports:
clk  input  1  single clock, all flops on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; held high by the caller until done is seen
opcode  input  3  0 NOP, 1 ADD, 2 SUB, 3 NOT, 4 XOR, 5 AND, 6 MUL, 7 INC
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
result  output  2*WIDTH  registered result
done  output  1  one-cycle completion pulse
busy  output  1  operation accepted and not yet completed

Behaviour:
- Reset (async assert, sync release): result=0, done=0, busy=0, state IDLE, MUL counter=0.
- Reset asserted mid-operation aborts it: no done, result=0.
- States: IDLE, MUL_RUN, DONE, REARM.
- IDLE: start sampled high at edge N accepts the op.
  - A, B and opcode are captured at edge N; later changes to them are ignored.
  - Non-MUL op goes to DONE at edge N; result and done are valid from edge N+1.
  - MUL goes to MUL_RUN at edge N, busy=1.
- MUL_RUN: counter runs MUL_LAT-1 cycles, then DONE.
  - done and result are valid from edge N+MUL_LAT.
  - start and opcode are ignored while in this state.
- DONE: done=1 for exactly one cycle and busy=0.
  - Next state is IDLE if start is sampled low, otherwise REARM.
- REARM: waits for start low, then IDLE. A start held high never triggers a second op.
- busy: high from the acceptance edge until the done edge, MUL only. Single-cycle ops never assert busy.
- Arithmetic: operands are zero-extended to 2*WIDTH; every result is modulo 2^(2*WIDTH).
  - ADD = A+B
  - SUB = A-B; negative results wrap, e.g. 3-5 gives all ones except LSB 0.
  - NOT = bitwise inverse of the zero-extended A, so the upper WIDTH bits are all ones.
  - XOR = A^B, AND = A&B, zero-extended.
  - MUL = full 2*WIDTH-bit unsigned product.
  - INC = A+B+1 (add with carry-in).
  - NOP: done pulses after 1 cycle; result holds its previous value.
- result changes only on the edge that raises done, or on reset.

Optional Feature:
ALU_FLAGS_EN:
- Defined: adds outputs flag_zero, flag_carry and flag_neg. Each updates on the same edge as result and resets to 0.
  - flag_zero: result == 0.
  - flag_carry: bit WIDTH of the result for ADD/INC; borrow (A<B) for SUB; 0 for all other ops.
  - flag_neg: bit WIDTH-1 of the result.
  - NOP holds all flags.
- Undefined: these ports and their logic are absent.

Test Plan:
- Reset: hold reset_n low 5 clocks with start=1 -> result=0, done=0, busy=0. After release, start high -> op accepted on the first edge.
- ADD (WIDTH=8): A=8'hFF, B=8'h01, start -> result=16'h0100, done one cycle after acceptance, busy stays 0. INC with the same operands -> 16'h0101.
- SUB/NOT: A=3, B=5 SUB -> 16'hFFFE. NOT with A=8'h0F -> 16'hFFF0.
- MUL (MUL_LAT=3): A=8'hFF, B=8'hFF -> result=16'hFE01 exactly 3 cycles after acceptance. busy high for those 3 cycles. Opcode/operand changes during MUL_RUN have no effect.
- Re-arm: keep start high for 4 cycles after done -> no second done. Drop start, raise it again with XOR A=8'hAA, B=8'hFF -> 16'h0055.
- Abort and flags: assert reset_n low 1 cycle into a MUL -> no done, result=0. With ALU_FLAGS_EN, ADD 8'hFF+8'h01 -> flag_carry=1, flag_zero=0, flag_neg=0.
